cpu_mem: RTL and testbench

CPU_MEM -- requirements
Module: cpu_mem

---
 rtl/cpu_mem_pkg.sv | 44 ++++
 rtl/cpu_mem_ram.sv | 46 ++++
 rtl/cpu_mem.sv | 140 ++++++++++++++
 tb/tb_cpu_mem.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared constants for the CPU program/data memory block.
//               Holds the memory geometry, the 3-bit opcode values shared
//               with the cpu core, the controller state encoding and a
//               saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  // Memory geometry
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W     = 16;

  // Opcodes shared with the cpu core (top 3 bits of an instruction word)
  localparam logic [2:0] OP_NOOP  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_STORE = 3'd6;
  localparam logic [2:0] OP_LOAD  = 3'd7;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_ram
// Description : Simple dual-port RAM, MEM_DEPTH x DATA_W. One synchronous
//               write port, one synchronous read port with one cycle of
//               latency. A same-edge write to the address being read is
//               forwarded to the read data (write-first).
// Ports       : clk      - clock, rising edge
//               we_i     - write enable
//               waddr_i  - write word address
//               wdata_i  - write data
//               raddr_i  - read word address
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_ram
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Storage is deliberately not reset: contents survive a controller reset.
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Write-first: a colliding write is returned instead of the stale word.
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cpu_mem.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem
// Description : Program/data memory for a small CPU with a LOAD -> RUN ->
//               HALT -> LOAD controller. In LOAD the host fills the memory;
//               in RUN the CPU fetches instructions and writes results; HALT
//               is a single quiet cycle before returning to LOAD.
// Ports       : clk               - clock, rising edge
//               reset             - synchronous active-high reset
//               load_valid/ready  - host program-load handshake
//               load_addr/data    - host load word address / data
//               start             - host pulse: LOAD -> RUN
//               halt_req          - host request: RUN -> HALT
//               run               - high while in RUN
//               fetch_addr        - CPU program counter
//               instruction_fetch - fetched word, 1-cycle latency, 0 unless RUN
//               wr_en/addr/data   - CPU result write
//               wr_count          - saturating count of accepted CPU writes
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              halt_req,
  output logic              run,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction_fetch,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  wr_count
);

  state_e             state_q, state_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  // --------------------------------------------------------------------------
  // State / counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      fetch_valid_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, write-port steering and counter update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = 1'b0;
    wr_count_d    = wr_count_q;
    mem_we        = 1'b0;
    mem_waddr     = wr_addr;
    mem_wdata     = wr_data;

    unique case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr;
          mem_wdata = load_data;
        end
        if (start) begin
          state_d    = ST_RUN;
          wr_count_d = '0;
        end
      end

      ST_RUN: begin
        // The read launched this cycle is only presented if we stay in RUN;
        // on a halt the following HALT cycle must show NOOP.
        fetch_valid_d = !halt_req;
        if (wr_en) begin
          mem_we     = 1'b1;
          wr_count_d = sat_inc(wr_count_q);
        end
        if (halt_req) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        state_d = ST_LOAD;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Reset wins over any write presented in the same cycle.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  cpu_mem_ram u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (fetch_addr),
    .rdata_o (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign load_ready        = (state_q == ST_LOAD);
  assign run               = (state_q == ST_RUN);
  // The RAM always reads; its data is masked to NOOP unless the read was
  // launched from a RUN cycle that did not halt.
  assign instruction_fetch = fetch_valid_q ? mem_rdata : {DATA_W{1'b0}};
  assign wr_count          = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem
// Description : Directed self-checking bench for cpu_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [10:0] load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        halt_req;
  logic        run;
  logic [10:0] fetch_addr;
  logic [31:0] instruction_fetch;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  int tests_run;
  int tests_failed;

  cpu_mem dut (
    .clk               (clk),
    .reset             (reset),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .start             (start),
    .halt_req          (halt_req),
    .run               (run),
    .fetch_addr        (fetch_addr),
    .instruction_fetch (instruction_fetch),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_count          (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    tests_run++;
    if (run !== 1'b0) begin tests_failed++; $display("FAIL reset_run got %b exp 0", run); end
    tests_run++;
    if (instruction_fetch !== 32'h0) begin tests_failed++; $display("FAIL reset_fetch got %h exp 0", instruction_fetch); end
    tests_run++;
    if (wr_count !== 16'h0) begin tests_failed++; $display("FAIL reset_wr_count got %h exp 0", wr_count); end
  endtask

  // Preload words used later, then try a CPU write while in LOAD.
  task automatic test_ignore_in_load();
    load_valid = 1'b1;
    load_addr = 11'h003; load_data = 32'hA5A5_0003; tick();
    load_addr = 11'h002; load_data = 32'h0000_2222; tick();
    load_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 11'h003; wr_data = 32'h0000_1234;
    halt_req = 1'b1;  // ignored outside RUN
    tick();
    wr_en = 1'b0; halt_req = 1'b0;
    tests_run++;
    if (wr_count !== 16'h0) begin tests_failed++; $display("FAIL load_wr_count got %h exp 0", wr_count); end
    tests_run++;
    if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL load_halt_ignored got load_ready=%b exp 1", load_ready); end
  endtask

  task automatic test_load_fetch();
    load_valid = 1'b1;
    load_addr = 11'h000; load_data = 32'h00C0_0001; tick();
    load_addr = 11'h001; load_data = 32'h0040_0002; start = 1'b1;
    fetch_addr = 11'h000;
    tick();
    load_valid = 1'b0; start = 1'b0;
    tests_run++;
    if (run !== 1'b1) begin tests_failed++; $display("FAIL start_run got %b exp 1", run); end
    tests_run++;
    if (instruction_fetch !== 32'h0) begin tests_failed++; $display("FAIL first_run_cycle_fetch got %h exp 0", instruction_fetch); end
    tests_run++;
    if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL run_load_ready got %b exp 0", load_ready); end
    fetch_addr = 11'h000; tick();
    tests_run++;
    if (instruction_fetch !== 32'h00C0_0001) begin tests_failed++; $display("FAIL fetch0 got %h exp 00c00001", instruction_fetch); end
    fetch_addr = 11'h001; tick();
    tests_run++;
    if (instruction_fetch !== 32'h0040_0002) begin tests_failed++; $display("FAIL fetch1 got %h exp 00400002", instruction_fetch); end
    fetch_addr = 11'h003; tick();
    tests_run++;
    if (instruction_fetch !== 32'hA5A5_0003) begin tests_failed++; $display("FAIL load_wr_ignored got %h exp a5a50003", instruction_fetch); end
  endtask

  task automatic test_run_ignores_load();
    load_valid = 1'b1; load_addr = 11'h002; load_data = 32'hFFFF_0000;
    start = 1'b1;  // ignored outside LOAD
    #1;
    tests_run++;
    if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL run_load_ready_valid got %b exp 0", load_ready); end
    tick();
    load_valid = 1'b0; start = 1'b0;
    fetch_addr = 11'h002; tick();
    tests_run++;
    if (instruction_fetch !== 32'h0000_2222) begin tests_failed++; $display("FAIL run_load_ignored got %h exp 00002222", instruction_fetch); end
    tests_run++;
    if (wr_count !== 16'h0) begin tests_failed++; $display("FAIL run_load_count got %h exp 0", wr_count); end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 11'h005; wr_data = 32'hDEAD_BEEF; fetch_addr = 11'h005;
    tick();
    wr_en = 1'b0;
    tests_run++;
    if (instruction_fetch !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL collision_fetch got %h exp deadbeef", instruction_fetch); end
    tests_run++;
    if (wr_count !== 16'h1) begin tests_failed++; $display("FAIL collision_count got %h exp 1", wr_count); end
  endtask

  task automatic test_halt();
    wr_en = 1'b1; wr_addr = 11'h006; wr_data = 32'h6666_6666; halt_req = 1'b1;
    fetch_addr = 11'h006;
    tick();
    halt_req = 1'b0;
    wr_addr = 11'h005; wr_data = 32'h0000_0BAD;  // write during HALT, ignored
    tests_run++;
    if (run !== 1'b0 || load_ready !== 1'b0 || instruction_fetch !== 32'h0) begin
      tests_failed++;
      $display("FAIL halt_outputs got run=%b ready=%b fetch=%h exp 0 0 0", run, load_ready, instruction_fetch);
    end
    tests_run++;
    if (wr_count !== 16'h2) begin tests_failed++; $display("FAIL halt_count got %h exp 2", wr_count); end
    tick();
    wr_en = 1'b0;
    tests_run++;
    if (load_ready !== 1'b1 || run !== 1'b0 || instruction_fetch !== 32'h0) begin
      tests_failed++;
      $display("FAIL halt_to_load got ready=%b run=%b fetch=%h exp 1 0 0", load_ready, run, instruction_fetch);
    end
    tests_run++;
    if (wr_count !== 16'h2) begin tests_failed++; $display("FAIL load_count_retained got %h exp 2", wr_count); end
    start = 1'b1; tick(); start = 1'b0;
    tests_run++;
    if (wr_count !== 16'h0) begin tests_failed++; $display("FAIL start_clears_count got %h exp 0", wr_count); end
    fetch_addr = 11'h006; tick();
    tests_run++;
    if (instruction_fetch !== 32'h6666_6666) begin tests_failed++; $display("FAIL halt_write_done got %h exp 66666666", instruction_fetch); end
    fetch_addr = 11'h005; tick();
    tests_run++;
    if (instruction_fetch !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL halt_write_ignored got %h exp deadbeef", instruction_fetch); end
  endtask

  task automatic test_saturate();
    wr_en = 1'b1; wr_addr = 11'h100;
    for (int i = 0; i < 65534; i++) begin
      wr_data = i;
      tick();
    end
    tests_run++;
    if (wr_count !== 16'hFFFE) begin tests_failed++; $display("FAIL count_65534 got %h exp fffe", wr_count); end
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    wr_en = 1'b0;
    tests_run++;
    if (wr_count !== 16'hFFFF) begin tests_failed++; $display("FAIL count_saturate got %h exp ffff", wr_count); end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();
    tests_run++;
    if (wr_count !== 16'hFFFF || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_count_persist got %h ready=%b exp ffff 1", wr_count, load_ready);
    end
    start = 1'b1; tick(); start = 1'b0;
    tests_run++;
    if (wr_count !== 16'h0) begin tests_failed++; $display("FAIL sat_start_clear got %h exp 0", wr_count); end
  endtask

  task automatic test_reset_midrun();
    fetch_addr = 11'h000; tick();
    wr_en = 1'b1; wr_addr = 11'h001; wr_data = 32'hBAD0_BAD0;
    start = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; start = 1'b0;
    tests_run++;
    if (run !== 1'b0 || load_ready !== 1'b1 || instruction_fetch !== 32'h0 || wr_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL midrun_reset got run=%b ready=%b fetch=%h cnt=%h exp 0 1 0 0", run, load_ready, instruction_fetch, wr_count);
    end
    start = 1'b1; tick(); start = 1'b0;
    fetch_addr = 11'h000; tick();
    tests_run++;
    if (instruction_fetch !== 32'h00C0_0001) begin tests_failed++; $display("FAIL post_reset_fetch0 got %h exp 00c00001", instruction_fetch); end
    fetch_addr = 11'h001; tick();
    tests_run++;
    if (instruction_fetch !== 32'h0040_0002) begin tests_failed++; $display("FAIL post_reset_fetch1 got %h exp 00400002", instruction_fetch); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; halt_req = 1'b0; fetch_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    test_reset();
    test_ignore_in_load();
    test_load_fetch();
    test_run_ignores_load();
    test_collision();
    test_halt();
    test_saturate();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
